comp_line_fill_engine: RTL and testbench

//  Line-fill engine between both icaches (raw and compressed) and memory. On a miss it

---
 rtl/comp_line_fill_engine.sv | 122 ++++++++++++
 tb/tb_comp_line_fill_engine.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/comp_line_fill_engine.sv
// Line-fill engine: fetches one cache line word-by-word (optionally critical word first),
// builds raw and dictionary-key lines side by side, and hands the line to exactly one icache.
module comp_line_fill_engine #(
  parameter int NUM_BLOCKS = 4,
  parameter int KEY_WIDTH  = 16,
  parameter int CWF        = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            miss_valid,
  output logic                            miss_ready,
  input  logic [31:0]                     miss_addr,
  input  logic                            comp_enable,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic [31:0]                     mem_req_addr,
  input  logic [31:0]                     mem_req_rdata,
  output logic [31:0]                     dict_lookup_word,
  input  logic                            dict_hit,
  input  logic [KEY_WIDTH-1:0]            dict_key,
  output logic                            raw_fill_valid,
  input  logic                            raw_fill_ready,
  output logic                            comp_fill_valid,
  input  logic                            comp_fill_ready,
  output logic [31:0]                     fill_addr,
  output logic [32*NUM_BLOCKS-1:0]        raw_fill_data,
  output logic [KEY_WIDTH*NUM_BLOCKS-1:0] comp_fill_data,
  output logic                            busy,
  output logic [CNT_WIDTH-1:0]            stat_fills,
  output logic [CNT_WIDTH-1:0]            stat_comp_fills
);

  localparam int OFF_W = $clog2(NUM_BLOCKS);
  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_t;

  state_t                          state;
  logic [31:0]                     base;
  logic [OFF_W-1:0]                widx;
  logic [OFF_W-1:0]                cnt;
  logic                            comp_ok;
  logic [32*NUM_BLOCKS-1:0]        raw_line;
  logic [KEY_WIDTH*NUM_BLOCKS-1:0] comp_line;
  logic                            word_comp_ok;
  logic                            fill_done;

  assign mem_req_addr     = base | {{(30-OFF_W){1'b0}}, widx, 2'b00};
  assign dict_lookup_word = mem_req_rdata;
  assign fill_addr        = base;
  assign raw_fill_data    = raw_line;
  assign comp_fill_data   = comp_line;

  // The line stays compressible only if every word so far, including this one, hit.
  assign word_comp_ok = comp_ok & dict_hit;
  assign fill_done    = (comp_fill_valid & comp_fill_ready) | (raw_fill_valid & raw_fill_ready);

  // NOTE: all state, including the line buffers, is updated with non-blocking assignments
  // and cleared on reset so a fill aborted by reset can never leak stale words.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      base            <= '0;
      widx            <= '0;
      cnt             <= '0;
      comp_ok         <= 1'b0;
      raw_line        <= '0;
      comp_line       <= '0;
      miss_ready      <= 1'b1;
      busy            <= 1'b0;
      mem_req_valid   <= 1'b0;
      raw_fill_valid  <= 1'b0;
      comp_fill_valid <= 1'b0;
      stat_fills      <= '0;
      stat_comp_fills <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss_valid) begin
            base          <= {miss_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
            widx          <= (CWF != 0) ? miss_addr[OFF_W+1:2] : '0;
            cnt           <= '0;
            comp_ok       <= comp_enable;
            miss_ready    <= 1'b0;
            busy          <= 1'b1;
            mem_req_valid <= 1'b1;
            state         <= FETCH;
          end
        end
        FETCH: begin
          if (mem_req_ready) begin
            raw_line[32*widx +: 32]               <= mem_req_rdata;
            comp_line[KEY_WIDTH*widx +: KEY_WIDTH] <= dict_key;
            comp_ok <= word_comp_ok;
            widx    <= widx + 1'b1;
            cnt     <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              mem_req_valid   <= 1'b0;
              comp_fill_valid <= word_comp_ok;
              raw_fill_valid  <= ~word_comp_ok;
              state           <= DELIVER;
            end
          end
        end
        DELIVER: begin
          if (fill_done) begin
            raw_fill_valid  <= 1'b0;
            comp_fill_valid <= 1'b0;
            miss_ready      <= 1'b1;
            busy            <= 1'b0;
            if (stat_fills != '1) stat_fills <= stat_fills + 1'b1;
            if (comp_fill_valid && stat_comp_fills != '1) stat_comp_fills <= stat_comp_fills + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_line_fill_engine.sv
// Directed bench for comp_line_fill_engine: CWF fetch order, raw/compressed selection,
// stalls and back-pressure, mid-fill reset and counter saturation (3-bit counters).
module tb_comp_line_fill_engine;

  localparam int NB = 4;
  localparam int KW = 16;
  localparam int CW = 3;
  localparam int SAT = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              miss_valid;
  logic              miss_ready;
  logic [31:0]       miss_addr;
  logic              comp_enable;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [31:0]       mem_req_addr;
  logic [31:0]       mem_req_rdata;
  logic [31:0]       dict_lookup_word;
  logic              dict_hit;
  logic [KW-1:0]     dict_key;
  logic              raw_fill_valid;
  logic              raw_fill_ready;
  logic              comp_fill_valid;
  logic              comp_fill_ready;
  logic [31:0]       fill_addr;
  logic [32*NB-1:0]  raw_fill_data;
  logic [KW*NB-1:0]  comp_fill_data;
  logic              busy;
  logic [CW-1:0]     stat_fills;
  logic [CW-1:0]     stat_comp_fills;

  logic [31:0] mem_seed;
  logic [3:0]  hit_mask;
  int n_vec = 0;
  int n_err = 0;
  int exp_fills = 0;
  int exp_comp = 0;

  comp_line_fill_engine #(.NUM_BLOCKS(NB), .KEY_WIDTH(KW), .CWF(1), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .comp_enable(comp_enable),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rdata(mem_req_rdata),
    .dict_lookup_word(dict_lookup_word), .dict_hit(dict_hit), .dict_key(dict_key),
    .raw_fill_valid(raw_fill_valid), .raw_fill_ready(raw_fill_ready),
    .comp_fill_valid(comp_fill_valid), .comp_fill_ready(comp_fill_ready),
    .fill_addr(fill_addr), .raw_fill_data(raw_fill_data), .comp_fill_data(comp_fill_data),
    .busy(busy), .stat_fills(stat_fills), .stat_comp_fills(stat_comp_fills)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] seed);
    return (a * 32'h9E37_79B9) ^ seed;
  endfunction

  function automatic logic [KW-1:0] key_of(input logic [31:0] w);
    return w[15:0] ^ w[31:16];
  endfunction

  function automatic int sat_inc(input int v);
    return (v < SAT) ? v + 1 : SAT;
  endfunction

  // Memory and dictionaries are modelled combinationally; hit_mask selects per-slot hits.
  assign mem_req_rdata = mem_word(mem_req_addr, mem_seed);
  assign dict_key      = key_of(dict_lookup_word);
  assign dict_hit      = hit_mask[mem_req_addr[3:2]];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 128'(busy), 128'(0));
    check({tag, " miss_ready"}, 128'(miss_ready), 128'(1));
    check({tag, " mem_req_valid"}, 128'(mem_req_valid), 128'(0));
    check({tag, " raw_fill_valid"}, 128'(raw_fill_valid), 128'(0));
    check({tag, " comp_fill_valid"}, 128'(comp_fill_valid), 128'(0));
    check({tag, " stat_fills"}, 128'(stat_fills), 128'(exp_fills));
    check({tag, " stat_comp_fills"}, 128'(stat_comp_fills), 128'(exp_comp));
  endtask

  // One complete miss: accept, fetch with `stall` idle cycles before each word,
  // hold the fill for `hold` cycles of back-pressure, then accept it.
  task automatic run_miss(input string tag, input logic [31:0] addr, input logic ce,
                          input logic [3:0] hitm, input int stall, input int hold,
                          input logic [31:0] seed);
    logic [31:0]      base;
    logic [31:0]      a;
    logic [1:0]       start;
    logic             exp_c;
    logic [32*NB-1:0] exp_raw;
    logic [KW*NB-1:0] exp_key;
    base  = addr & ~32'hF;
    start = addr[3:2];
    exp_c = ce && (hitm == 4'hF);
    for (int i = 0; i < NB; i++) begin
      exp_raw[32*i +: 32] = mem_word(base | (i << 2), seed);
      exp_key[KW*i +: KW] = key_of(mem_word(base | (i << 2), seed));
    end

    @(negedge clk);
    mem_seed = seed;
    hit_mask = hitm;
    check({tag, " accept ready"}, 128'(miss_ready), 128'(1));
    miss_valid  = 1'b1;
    miss_addr   = addr;
    comp_enable = ce;
    @(negedge clk);
    miss_valid  = 1'b0;
    comp_enable = ~ce;
    check({tag, " busy"}, 128'(busy), 128'(1));

    for (int w = 0; w < NB; w++) begin
      a = base | (((32'(start) + 32'(w)) % NB) << 2);
      for (int s = 0; s < stall; s++) begin
        check({tag, " stall valid"}, 128'(mem_req_valid), 128'(1));
        check({tag, " stall addr"}, 128'(mem_req_addr), 128'(a));
        @(negedge clk);
      end
      check({tag, " req valid"}, 128'(mem_req_valid), 128'(1));
      check({tag, " req addr"}, 128'(mem_req_addr), 128'(a));
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
    end

    check({tag, " req dropped"}, 128'(mem_req_valid), 128'(0));
    check({tag, " fill_addr"}, 128'(fill_addr), 128'(base));
    for (int h = 0; h <= hold; h++) begin
      check({tag, " comp_fill_valid"}, 128'(comp_fill_valid), 128'(exp_c));
      check({tag, " raw_fill_valid"}, 128'(raw_fill_valid), 128'(!exp_c));
      check({tag, " raw data"}, 128'(raw_fill_data), 128'(exp_raw));
      check({tag, " comp data"}, 128'(comp_fill_data), 128'(exp_key));
      if (h < hold) begin
        // Ready on the cache that was not selected must be ignored.
        raw_fill_ready  = exp_c;
        comp_fill_ready = !exp_c;
        @(negedge clk);
      end
    end
    raw_fill_ready  = !exp_c;
    comp_fill_ready = exp_c;
    @(negedge clk);
    raw_fill_ready  = 1'b0;
    comp_fill_ready = 1'b0;
    exp_fills = sat_inc(exp_fills);
    if (exp_c) exp_comp = sat_inc(exp_comp);
    check_idle({tag, " done"});
  endtask

  initial begin
    reset = 1'b1;
    miss_valid = 1'b0;
    miss_addr = '0;
    comp_enable = 1'b0;
    mem_req_ready = 1'b0;
    raw_fill_ready = 1'b0;
    comp_fill_ready = 1'b0;
    mem_seed = 32'h0;
    hit_mask = 4'hF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_idle("reset");
    check("reset raw data", 128'(raw_fill_data), 128'(0));
    check("reset fill_addr", 128'(fill_addr), 128'(0));

    run_miss("T1", 32'h0000_1008, 1'b1, 4'hF, 0, 0, 32'h1111_0000);
    run_miss("T2", 32'h0000_1008, 1'b1, 4'hE, 0, 0, 32'h2222_0000);
    run_miss("T3", 32'h0000_1008, 1'b0, 4'hF, 0, 0, 32'h3333_0000);
    run_miss("T4", 32'h0000_3004, 1'b1, 4'hF, 3, 5, 32'h4444_0000);
    run_miss("T4raw", 32'h0000_3F0C, 1'b1, 4'h7, 3, 5, 32'h4545_0000);

    // T5: reset after two of four words, then a fresh fill with new memory contents.
    @(negedge clk);
    mem_seed = 32'h5555_0000;
    hit_mask = 4'hF;
    miss_valid = 1'b1;
    miss_addr = 32'h0000_2004;
    comp_enable = 1'b1;
    @(negedge clk);
    miss_valid = 1'b0;
    mem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_fills = 0;
    exp_comp = 0;
    check_idle("T5 reset");
    check("T5 raw cleared", 128'(raw_fill_data), 128'(0));
    check("T5 comp cleared", 128'(comp_fill_data), 128'(0));
    run_miss("T5fresh", 32'h0000_2004, 1'b1, 4'hF, 0, 0, 32'h6666_0000);

    // T6: keep filling until both counters pin at all-ones.
    for (int i = 0; i < 8; i++)
      run_miss("T6", 32'h0000_5000 + 32'(i) * 32'h10, 1'b1, 4'hF, 0, 1, 32'h7000_0000 + 32'(i));
    check("T6 fills saturated", 128'(stat_fills), 128'(SAT));
    check("T6 comp saturated", 128'(stat_comp_fills), 128'(SAT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
